// File: rtl/ff_mem_arbiter.sv
// Arbiter and sequencer sharing one asynchronous SRAM between the CPU bus bridge and the
// video line fetch. Video wins contention unless the CPU has already waited CPU_MAX_WAIT cycles.
module ff_mem_arbiter #(
  parameter int AW            = 18,
  parameter int DW            = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int CPU_MAX_WAIT  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_dout_en,
  input  logic [DW-1:0] mem_din,
  output logic          mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic          busy
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int WW = $clog2(CPU_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          own_cpu;
  logic          own_we;
  logic [WW-1:0] cpu_wait;

  logic          grant_cpu;
  logic          grant_vid;
  logic          last_beat;
  logic          own_cpu_nxt;
  logic          own_we_nxt;
  logic          ce_n_nxt;
  logic          oe_n_nxt;
  logic          we_n_nxt;
  logic          dout_en_nxt;
  logic          cpu_ack_nxt;
  logic          vid_ack_nxt;

  // Next-state and next-strobe decode; strobes are registered so the SRAM pins never glitch.
  always_comb begin
    state_nxt   = state;
    grant_cpu   = 1'b0;
    grant_vid   = 1'b0;
    last_beat   = (state == ACCESS) && (cnt == CW'(ACCESS_CYCLES - 1));
    case (state)
      IDLE: begin
        if (cpu_req && (!vid_req || cpu_wait >= WW'(CPU_MAX_WAIT))) begin
          grant_cpu = 1'b1;
        end else if (vid_req) begin
          grant_vid = 1'b1;
        end
        if (grant_cpu || grant_vid) state_nxt = ACCESS;
      end
      ACCESS:  if (last_beat) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    own_cpu_nxt = own_cpu;
    own_we_nxt  = own_we;
    if (grant_cpu) begin
      own_cpu_nxt = 1'b1;
      own_we_nxt  = cpu_we;
    end else if (grant_vid) begin
      own_cpu_nxt = 1'b0;
      own_we_nxt  = 1'b0;
    end

    ce_n_nxt    = !(state_nxt == ACCESS);
    oe_n_nxt    = !((state_nxt == ACCESS) && !own_we_nxt);
    we_n_nxt    = !((state_nxt == ACCESS) && own_we_nxt);
    dout_en_nxt = (state_nxt == ACCESS) && own_we_nxt;
    cpu_ack_nxt = (state_nxt == RECOVER) && own_cpu_nxt;
    vid_ack_nxt = (state_nxt == RECOVER) && !own_cpu_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Access sequencing: beat counter, ownership and the fairness counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      own_cpu  <= 1'b0;
      own_we   <= 1'b0;
      cpu_wait <= '0;
    end else begin
      own_cpu <= own_cpu_nxt;
      own_we  <= own_we_nxt;
      if (grant_cpu || grant_vid) begin
        cnt <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
      end
      // Counts every cycle the CPU is asking but not being granted, video service included.
      if (grant_cpu) begin
        cpu_wait <= '0;
      end else if (cpu_req && (cpu_wait < WW'(CPU_MAX_WAIT))) begin
        cpu_wait <= cpu_wait + WW'(1);
      end
    end
  end

  // SRAM pin drivers and completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ce_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_dout_en <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
    end else begin
      mem_ce_n    <= ce_n_nxt;
      mem_oe_n    <= oe_n_nxt;
      mem_we_n    <= we_n_nxt;
      mem_dout_en <= dout_en_nxt;
      cpu_ack     <= cpu_ack_nxt;
      vid_ack     <= vid_ack_nxt;
    end
  end

  // Address/data capture on the grant edge; read data lands on the edge ending the last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_dout  <= '0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      if (grant_cpu) begin
        mem_addr <= cpu_addr;
        if (cpu_we) mem_dout <= cpu_wdata;
      end else if (grant_vid) begin
        mem_addr <= vid_addr;
      end
      if (last_beat && !own_we) begin
        if (own_cpu) begin
          cpu_rdata <= mem_din;
        end else begin
          vid_rdata <= mem_din;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ff_mem_arbiter.sv
// Bench for ff_mem_arbiter: transaction-schedule reference model, a small SRAM model,
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_ff_mem_arbiter;
  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int AC   = 2;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          mem_dout_en;
  logic [DW-1:0] mem_din;
  logic          mem_ce_n, mem_oe_n, mem_we_n;
  logic          busy;

  always #5 clk = ~clk;

  ff_mem_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC), .CPU_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_dout_en(mem_dout_en), .mem_din(mem_din),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .busy(busy)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 16'(i * 4369) ^ 16'h5A5A;
  endfunction

  // SRAM model: 32 words decoded from the low address bits.
  logic          sram_ready = 1'b0;
  logic [DW-1:0] sram [0:31];
  assign mem_din = !mem_oe_n ? sram[mem_addr[4:0]] : 16'h0BAD;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 32; i++) sram[i] <= init_word(i);
    end else if (!mem_ce_n && !mem_we_n && mem_dout_en) begin
      sram[mem_addr[4:0]] <= mem_dout;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act_v, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s @cycle %0d: got no ack, required one within bound", name, cyc);
  endtask

  // Reference model: one transaction at a time, outputs derived from cycles since grant.
  longint        cyc = 0;
  bit            act = 0;
  longint        g = 0;
  bit            t_cpu = 0, t_we = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_rdata = '0;
  int            m_wait = 0;
  logic [DW-1:0] shadow [0:31];
  logic [DW-1:0] e_cpu_rdata = '0, e_vid_rdata = '0, e_dout = '0;
  logic [AW-1:0] e_addr = '0;

  // Requester drivers.
  bit            cpu_pend = 0, vid_pend = 0;
  bit            c_we = 0;
  logic [AW-1:0] c_addr = '0, v_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  int            cpu_rate = 0, vid_rate = 0;

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return {r[12:0], 1'b0, r[3:0]};
  endfunction

  task automatic model_reset();
    act = 0; m_wait = 0;
    e_cpu_rdata = '0; e_vid_rdata = '0; e_dout = '0; e_addr = '0;
  endtask

  task automatic issue_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_pend = 1; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic issue_vid(input logic [AW-1:0] a);
    vid_pend = 1; v_addr = a;
  endtask

  task automatic step();
    longint k;
    bit acc, ack_c, ack_v;
    logic [6:0] e_str;
    @(negedge clk);
    cyc++;
    if (act && (cyc - g) > AC + 1) act = 0;
    k     = act ? cyc - g : 0;
    acc   = act && k >= 1 && k <= AC;
    ack_c = act && k == AC + 1 && t_cpu;
    ack_v = act && k == AC + 1 && !t_cpu;
    if (act && k == AC + 1 && !t_we) begin
      if (t_cpu) e_cpu_rdata = t_rdata;
      else       e_vid_rdata = t_rdata;
    end
    e_str = {!acc, !(acc && !t_we), !(acc && t_we), acc && t_we, act, ack_c, ack_v};
    chk("strobes{ce,oe,we,den,busy,cack,vack}",
        32'({mem_ce_n, mem_oe_n, mem_we_n, mem_dout_en, busy, cpu_ack, vid_ack}), 32'(e_str));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_dout", 32'(mem_dout), 32'(e_dout));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
    chk("vid_rdata", 32'(vid_rdata), 32'(e_vid_rdata));

    if (ack_c) cpu_pend = 0;
    if (ack_v) vid_pend = 0;
    if (!cpu_pend && $urandom_range(99, 0) < cpu_rate)
      issue_cpu(1'($urandom_range(1, 0)), rand_addr(), 16'($urandom));
    if (!vid_pend && $urandom_range(99, 0) < vid_rate) issue_vid(rand_addr());
    cpu_req = cpu_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    vid_req = vid_pend; vid_addr = v_addr;

    if (!act && (cpu_pend || vid_pend)) begin
      act   = 1;
      g     = cyc;
      t_cpu = cpu_pend && (!vid_pend || m_wait >= MAXW);
      if (t_cpu) begin
        t_we = c_we; t_addr = c_addr;
        if (c_we) begin
          e_dout = c_wdata;
          shadow[c_addr[4:0]] = c_wdata;
        end else begin
          t_rdata = shadow[c_addr[4:0]];
        end
      end else begin
        t_we = 0; t_addr = v_addr; t_rdata = shadow[v_addr[4:0]];
      end
      e_addr = t_addr;
    end
    if (act && g == cyc && t_cpu) m_wait = 0;
    else if (cpu_pend && m_wait < MAXW) m_wait++;
  endtask

  task automatic wait_ack(input bit for_cpu, input string name, output longint at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (for_cpu ? cpu_ack : vid_ack) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_now(name);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (!act && !cpu_pend && !vid_pend) break;
      step();
    end
  endtask

  initial begin
    longint t0, at, va, ca;
    int nv, nwe, extra;
    logic [AW-1:0] a;

    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    repeat (3) @(negedge clk);
    sram_ready = 1'b1;
    chk("reset_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_dout_en, busy, cpu_ack, vid_ack}),
        32'(7'b1110000));
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_rdata", 32'({cpu_rdata, vid_rdata}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Reset in the middle of a CPU write.
    issue_cpu(1'b1, 18'h00130, 16'h1234);
    step();
    step();
    chk("abort_pre_we_n", 32'(mem_we_n), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_strobes{ce,we,den,busy}", 32'({mem_ce_n, mem_we_n, mem_dout_en, busy}), 32'(4'b1100));
    cpu_pend = 0; cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(cpu_ack), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // CPU write then read-back of the same word.
    t0 = cyc + 1;
    issue_cpu(1'b1, 18'h00123, 16'hBEEF);
    wait_ack(1'b1, "wr_ack", at);
    chk("wr_latency", 32'(at - t0), 32'd3);
    t0 = cyc + 1;
    issue_cpu(1'b0, 18'h00123, 16'h0000);
    wait_ack(1'b1, "rd_ack", at);
    chk("rd_latency", 32'(at - t0), 32'd3);
    chk("rd_data", 32'(cpu_rdata), 32'h0000BEEF);

    // Video alone, request held continuously.
    drain();
    vid_rate = 100;
    va = -1; nv = 0; nwe = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!mem_we_n) nwe++;
      if (vid_ack) begin
        if (va >= 0) chk("vid_period", 32'(cyc - va), 32'd4);
        va = cyc;
        nv++;
      end
    end
    chk("vid_ack_count", 32'(nv), 32'd5);
    chk("vid_no_write", 32'(nwe), 32'd0);
    chk("vid_cpu_rdata_kept", 32'(cpu_rdata), 32'h0000BEEF);
    vid_rate = 0;
    drain();

    // Contention from one IDLE cycle, then both drop after their acks.
    t0 = cyc + 1;
    issue_cpu(1'b0, rand_addr(), 16'h0000);
    issue_vid(rand_addr());
    va = -1; ca = -1; extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ca >= 0 && (busy || cpu_ack || vid_ack)) extra++;
      if (vid_ack && va < 0) va = cyc;
      if (cpu_ack && ca < 0) ca = cyc;
    end
    chk("cont_vid_first", 32'(va - t0), 32'd3);
    chk("cont_cpu_next", 32'(ca - va), 32'd4);
    chk("drop_stays_idle", 32'(extra), 32'd0);
    drain();

    // Starvation bound with video requesting permanently; a second CPU request waits again.
    vid_rate = 100;
    for (int rep = 0; rep < 2; rep++) begin
      t0 = cyc + 1;
      a = rand_addr();
      issue_cpu(1'b0, a, 16'h0000);
      nv = 0; ca = -1;
      for (int i = 0; i < 40; i++) begin
        step();
        if (vid_ack) nv++;
        if (cpu_ack) begin
          ca = cyc;
          break;
        end
      end
      if (ca < 0) fail_now("starve_cpu_ack");
      chk(rep == 0 ? "starve_vid_acks" : "rewait_vid_acks", 32'(nv), 32'd2);
      chk(rep == 0 ? "starve_latency" : "rewait_latency", 32'(ca - t0), 32'd11);
    end
    vid_rate = 0;
    drain();

    // Randomized traffic.
    for (int seg = 0; seg < 6; seg++) begin
      cpu_rate = int'($urandom_range(100, 5));
      vid_rate = int'($urandom_range(100, 0));
      repeat (500) step();
    end
    cpu_rate = 0;
    vid_rate = 0;
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
